// File: rtl/vram_arbiter.sv
// VRAM port arbiter: scanout reads win, queued pixel writes fill idle cycles.
// Optional full-VRAM fill engine enabled with `define VRAM_FILL_EN.
module vram_arbiter #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 230400,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_disp_req,
  input  logic [ADDR_WIDTH-1:0] i_disp_addr,
  output logic [DATA_WIDTH-1:0] o_disp_data,
  output logic                  o_disp_valid,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_fill_start,
  input  logic [DATA_WIDTH-1:0] i_fill_colour,
  output logic                  o_fill_busy,
  output logic                  o_fill_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];

  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  mem_write_q, mem_write_d;
  logic                  disp_pend_q, disp_pend_d;
  logic                  disp_valid_q, disp_valid_d;

  logic                  empty, full, push;
  logic                  disp_gnt, fifo_gnt, fill_gnt;
  logic                  fill_want, fill_block;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [DATA_WIDTH-1:0] fill_colour;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));

  assign o_wr_ready = !i_rst && !full && !fill_block;
  assign push       = i_wr_valid && o_wr_ready;

  // Grant uses the registered count, so a fresh push waits a cycle.
  assign disp_gnt = i_disp_req;
  assign fifo_gnt = !i_disp_req && !empty;
  assign fill_gnt = !i_disp_req && empty && fill_want;

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_write_d = 1'b0;
    unique case (1'b1)
      disp_gnt: begin
        mem_addr_d = i_disp_addr;
      end
      fifo_gnt: begin
        mem_addr_d  = fifo_addr_q[rd_ptr_q];
        mem_data_d  = fifo_data_q[rd_ptr_q];
        mem_write_d = 1'b1;
      end
      fill_gnt: begin
        mem_addr_d  = fill_addr;
        mem_data_d  = fill_colour;
        mem_write_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    count_d      = count_q + CW'(push) - CW'(fifo_gnt);
    rd_ptr_d     = rd_ptr_q + PW'(fifo_gnt);
    wr_ptr_d     = wr_ptr_q + PW'(push);
    disp_pend_d  = disp_gnt;
    disp_valid_d = disp_pend_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_write_q  <= 1'b0;
      disp_pend_q  <= 1'b0;
      disp_valid_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_write_q  <= mem_write_d;
      disp_pend_q  <= disp_pend_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= i_wr_addr;
      fifo_data_q[wr_ptr_q] <= i_wr_data;
    end
  end

  assign o_mem_addr   = mem_addr_q;
  assign o_mem_data   = mem_data_q;
  assign o_mem_write  = mem_write_q;
  assign o_disp_valid = disp_valid_q;
  assign o_disp_data  = i_mem_data;

`ifdef VRAM_FILL_EN
  typedef enum logic [1:0] {
    F_IDLE,
    F_FLUSH,
    F_FILL,
    F_DONE
  } fill_state_e;

  fill_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
  logic [DATA_WIDTH-1:0] colour_q, colour_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    colour_d    = colour_q;
    unique case (state_q)
      F_IDLE: begin
        if (i_fill_start) begin
          colour_d = i_fill_colour;
          state_d  = F_FLUSH;
        end
      end
      F_FLUSH: begin
        if (empty) begin
          fill_addr_d = '0;
          state_d     = F_FILL;
        end
      end
      F_FILL: begin
        if (fill_gnt) begin
          fill_addr_d = fill_addr_q + ADDR_WIDTH'(1);
          if (fill_addr_q == LAST_ADDR) state_d = F_DONE;
        end
      end
      F_DONE: begin
        state_d = F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase
    busy_d = (state_d != F_IDLE);
    done_d = (state_d == F_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= F_IDLE;
      fill_addr_q <= '0;
      colour_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      colour_q    <= colour_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign fill_want   = (state_q == F_FILL);
  assign fill_block  = busy_q;
  assign fill_addr   = fill_addr_q;
  assign fill_colour = colour_q;
  assign o_fill_busy = busy_q;
  assign o_fill_done = done_q;
`else
  logic unused_fill;
  assign unused_fill = ^{i_fill_start, i_fill_colour, LAST_ADDR};

  assign fill_want   = 1'b0;
  assign fill_block  = 1'b0;
  assign fill_addr   = '0;
  assign fill_colour = '0;
  assign o_fill_busy = 1'b0;
  assign o_fill_done = 1'b0;
`endif

endmodule
